// File: rtl/hs_npu_mm_sequencer.sv
// Job sequencer for an N x N systolic MAC array: weight load, row streaming, drain.
// Optional cycle counter output perf_cycles when HS_NPU_SEQ_PERF_EN is defined.
module hs_npu_mm_sequencer #(
  parameter int ARRAY_SIZE = 8,
  parameter int ROW_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROW_W-1:0]              num_rows,
  output logic                          ready,
  output logic                          weight_en,
  output logic [$clog2(ARRAY_SIZE)-1:0] weight_row,
  output logic                          in_valid,
  output logic [ROW_W-1:0]              in_row,
  output logic                          res_valid,
  output logic [ROW_W-1:0]              res_row,
  output logic                          done
`ifdef HS_NPU_SEQ_PERF_EN
  ,
  output logic [31:0]                   perf_cycles
`endif
);
  localparam int N    = ARRAY_SIZE;
  localparam int WR_W = $clog2(ARRAY_SIZE);
  localparam int DLY  = 2 * ARRAY_SIZE;

  typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, FIN} state_t;

  state_t           state, state_nxt;
  logic [ROW_W-1:0] cnt, m_lat, res_cnt;
  logic [DLY-1:0]   vld_pipe;
  logic             zero_done, accept, phase_end;

  assign accept = (state == IDLE) && start && (num_rows != '0);

  always_comb begin
    phase_end = 1'b0;
    case (state)
      LOAD_W:  phase_end = (cnt == ROW_W'(N - 1));
      COMPUTE: phase_end = (cnt == m_lat - 1'b1);
      DRAIN:   phase_end = (cnt == ROW_W'(DLY - 1));
      default: phase_end = 1'b0;
    endcase
  end

  // state register and phase counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      m_lat     <= '0;
      zero_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= (state_nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
      zero_done <= (state == IDLE) && start && (num_rows == '0);
      if (accept) m_lat <= num_rows;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = LOAD_W;
      LOAD_W:  if (phase_end) state_nxt = COMPUTE;
      COMPUTE: if (phase_end) state_nxt = DRAIN;
      DRAIN:   if (phase_end) state_nxt = FIN;
      FIN:                    state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready      = 1'b0;
    weight_en  = 1'b0;
    weight_row = '0;
    in_valid   = 1'b0;
    in_row     = '0;
    case (state)
      IDLE: ready = 1'b1;
      LOAD_W: begin
        weight_en  = 1'b1;
        weight_row = WR_W'(N - 1) - cnt[WR_W-1:0];
      end
      COMPUTE: begin
        in_valid = 1'b1;
        in_row   = cnt;
      end
      default: ;
    endcase
    done      = (state == FIN) || zero_done;
    res_valid = vld_pipe[DLY-1];
    res_row   = res_cnt;
  end

  // rows emerge from the deskew exactly 2N cycles after injection
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      res_cnt  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[DLY-2:0], in_valid};
      if (accept)         res_cnt <= '0;
      else if (res_valid) res_cnt <= res_cnt + 1'b1;
    end
  end

`ifdef HS_NPU_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start))            perf_cycles <= '0;
    else if (state != IDLE && perf_cycles != '1)   perf_cycles <= perf_cycles + 1'b1;
  end
`endif
endmodule

// File: tb/tb_hs_npu_mm_sequencer.sv
// Bench for hs_npu_mm_sequencer (N=4): directed table, corner sequences, random jobs vs job-timeline model.
module tb_hs_npu_mm_sequencer;
  localparam int N  = 4;
  localparam int RW = 8;
  localparam int WRW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [RW-1:0]  num_rows = '0;
  logic           ready, weight_en, in_valid, res_valid, done;
  logic [WRW-1:0] weight_row;
  logic [RW-1:0]  in_row, res_row;
`ifdef HS_NPU_SEQ_PERF_EN
  logic [31:0]    perf_cycles;
`endif

  always #5 clk = ~clk;

  hs_npu_mm_sequencer #(.ARRAY_SIZE(N), .ROW_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .ready(ready), .weight_en(weight_en), .weight_row(weight_row),
    .in_valid(in_valid), .in_row(in_row), .res_valid(res_valid),
    .res_row(res_row), .done(done)
`ifdef HS_NPU_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  int n_vec = 0, n_err = 0;

  // model: a job is a timeline indexed by k = cycles since the start edge
  bit     m_busy = 0, m_zdone = 0, m_rstd = 0;
  int     m_k = 0, m_m = 0;
  longint m_perf = 0;

  typedef struct {
    bit r, s; int nr;
    bit rdy, wen, inv, resv, dn; int row;
  } vec_t;
  vec_t tbl[18];

  function automatic vec_t rec(bit r, bit s, int nr, bit rdy, bit wen, bit inv, bit resv, bit dn, int row);
    vec_t v;
    v.r = r; v.s = s; v.nr = nr; v.rdy = rdy; v.wen = wen; v.inv = inv;
    v.resv = resv; v.dn = dn; v.row = row;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input int nr);
    bit was_busy;
    was_busy = m_busy;
    if (r) begin
      m_busy = 0; m_zdone = 0; m_rstd = 1; m_perf = 0;
    end else begin
      m_rstd = 0; m_zdone = 0;
      if (was_busy) begin
        if (m_perf != 64'hFFFF_FFFF) m_perf++;
        if (m_k == 3*N + m_m + 1) m_busy = 0;
        else m_k++;
      end else if (s) begin
        m_perf = 0;
        if (nr == 0) m_zdone = 1;
        else begin m_busy = 1; m_k = 1; m_m = nr; end
      end
    end
  endtask

  task automatic check_model();
    bit b, wen, inv, resv, dn;
    int k;
    b = m_busy; k = m_k;
    wen  = b && k <= N;
    inv  = b && k > N && k <= N + m_m;
    resv = b && k > 3*N && k <= 3*N + m_m;
    dn   = m_zdone || (b && k == 3*N + m_m + 1);
    chk("ready", ready, !b);
    chk("weight_en", weight_en, wen);
    chk("in_valid", in_valid, inv);
    chk("res_valid", res_valid, resv);
    chk("done", done, dn);
    if (wen)  chk("weight_row", weight_row, N - k);
    if (inv)  chk("in_row", in_row, k - N - 1);
    if (resv) chk("res_row", res_row, k - 3*N - 1);
    if (m_rstd) begin
      chk("rst_weight_row", weight_row, 0);
      chk("rst_in_row", in_row, 0);
      chk("rst_res_row", res_row, 0);
    end
`ifdef HS_NPU_SEQ_PERF_EN
    chk("perf_cycles", perf_cycles, m_perf[31:0]);
`endif
  endtask

  task automatic cyc(input bit r, input bit s, input int nr);
    rst = r; start = s; num_rows = RW'(nr);
    model_edge(r, s, nr);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    // rst, then an M=3 job, spec cycle i is the cycle after record i's edge
    tbl[0]  = rec(1, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = rec(0, 1, 3, 0, 1, 0, 0, 0, 3);
    tbl[2]  = rec(0, 0, 0, 0, 1, 0, 0, 0, 2);
    tbl[3]  = rec(0, 0, 0, 0, 1, 0, 0, 0, 1);
    tbl[4]  = rec(0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[5]  = rec(0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[6]  = rec(0, 0, 0, 0, 0, 1, 0, 0, 1);
    tbl[7]  = rec(0, 0, 0, 0, 0, 1, 0, 0, 2);
    for (int i = 8; i <= 12; i++) tbl[i] = rec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = rec(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[14] = rec(0, 0, 0, 0, 0, 0, 1, 0, 1);
    tbl[15] = rec(0, 0, 0, 0, 0, 0, 1, 0, 2);
    tbl[16] = rec(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[17] = rec(0, 0, 0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].r, tbl[i].s, tbl[i].nr);
      chk("t_ready", ready, tbl[i].rdy);
      chk("t_weight_en", weight_en, tbl[i].wen);
      chk("t_in_valid", in_valid, tbl[i].inv);
      chk("t_res_valid", res_valid, tbl[i].resv);
      chk("t_done", done, tbl[i].dn);
      if (tbl[i].wen)  chk("t_weight_row", weight_row, tbl[i].row);
      if (tbl[i].inv)  chk("t_in_row", in_row, tbl[i].row);
      if (tbl[i].resv) chk("t_res_row", res_row, tbl[i].row);
    end
`ifdef HS_NPU_SEQ_PERF_EN
    chk("t_perf_m3", perf_cycles, 16);
`endif

    // M=0: done next cycle, nothing else
    cyc(0, 1, 0);
    chk("m0_done", done, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0);

    // start pulsed during COMPUTE is ignored
    cyc(0, 1, 5);
    for (int i = 0; i < N + 2; i++) cyc(0, 0, 0);
    cyc(0, 1, 7);
    for (int i = 0; i < 3*N + 8; i++) cyc(0, 0, 0);

    // rst on the 2nd in_valid cycle aborts the job
    cyc(0, 1, 3);
    for (int i = 0; i < N + 1; i++) cyc(0, 0, 0);
    chk("abort_inv2", in_valid, 1);
    cyc(1, 0, 0);
    for (int i = 0; i < 3*N + 6; i++) cyc(0, 0, 0);

    // back-to-back M=2 then M=1
    cyc(0, 1, 2);
    for (int i = 0; i < 100 && !done; i++) cyc(0, 0, 0);
    chk("b2b_done_seen", done, 1);
    cyc(0, 0, 0);
    cyc(0, 1, 1);
    chk("b2b_wen", weight_en, 1);
    for (int i = 0; i < 3*N + 4; i++) cyc(0, 0, 0);

    // largest job: M = 2^ROW_W - 1
    cyc(0, 1, 255);
    for (int i = 0; i < 3*N + 257; i++) cyc(0, 0, 0);

    // random traffic
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 6));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
